// File: rtl/mmu_tile_seq_if.sv
// mmu_tile_seq_if
//   Bundles every signal the tile sequencer exchanges with the outside world
//   apart from clock and reset: the job-control handshake towards the layer
//   control FSM and the enable/ready handshake towards the MMU, plus the
//   operand-select outputs that steer the tile muxes.
//
//   Signals
//     start          job request, one cycle, only honoured when idle
//     num_k_tiles    tile count N, sampled together with start
//     abort          synchronous abort of the running job
//     busy           job in progress
//     done           one-cycle pulse on successful completion
//     error          sticky watchdog timeout flag
//     mmu_enable     MMU enable level, held until mmu_data_ready
//     mmu_data_ready MMU completion pulse
//     k_idx          tile index of the current MMU operation
//     accum_sel      0 = accumulate from bias/zero, 1 = from fed-back output
//
//   Modports
//     slave  : the sequencer itself
//     master : the environment (control FSM + MMU) that drives the sequencer
interface mmu_tile_seq_if #(
  parameter int KT_W = 4
);

  logic            start;
  logic [KT_W-1:0] num_k_tiles;
  logic            abort;
  logic            busy;
  logic            done;
  logic            error;
  logic            mmu_enable;
  logic            mmu_data_ready;
  logic [KT_W-1:0] k_idx;
  logic            accum_sel;

  modport slave (
    input  start,
    input  num_k_tiles,
    input  abort,
    input  mmu_data_ready,
    output busy,
    output done,
    output error,
    output mmu_enable,
    output k_idx,
    output accum_sel
  );

  modport master (
    output start,
    output num_k_tiles,
    output abort,
    output mmu_data_ready,
    input  busy,
    input  done,
    input  error,
    input  mmu_enable,
    input  k_idx,
    input  accum_sel
  );

endinterface

// File: rtl/mmu_tile_seq.sv
// mmu_tile_seq
//   Sequences the short-latency matrix-multiply unit over a K-tiled product.
//   A job of N tiles issues N MMU operations back to back. For each operation
//   the sequencer presents the tile index and accumulate source, raises
//   mmu_enable and keeps it high until the MMU pulses mmu_data_ready. Between
//   operations mmu_enable stays low for GAP_CYCLES cycles. A watchdog ends the
//   job with a sticky error if an operation stays enabled for TIMEOUT cycles
//   without completing.
//
//   Ports
//     clk    clock
//     rst_n  asynchronous active-low reset
//     bus    mmu_tile_seq_if.slave (job handshake, MMU handshake, operand select)
//
//   Every output is a flop; nothing combinational runs from an input to an
//   output.
module mmu_tile_seq #(
  parameter int KT_W       = 4,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 15,
  parameter int TO_W       = 4
) (
  input logic          clk,
  input logic          rst_n,
  mmu_tile_seq_if.slave bus
);

  // The gap counter only has to reach GAP_CYCLES-1, so one bit is enough
  // for the minimum gap of a single cycle.
  localparam int GC_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [GC_W-1:0] GAP_LAST = GC_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0] WD_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP,
    ERR
  } state_t;

  state_t          state;
  logic [KT_W-1:0] last_k;
  logic [KT_W-1:0] k_q;
  logic            acc_q;
  logic            en_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic [TO_W-1:0] wd_cnt;
  logic [GC_W-1:0] gap_cnt;

  // Index of the final tile is kept instead of N itself so the completion
  // test in ISSUE is a plain equality against a register.
  //
  // wd_cnt holds the number of enable-high cycles already completed in the
  // current window, so it reaches TIMEOUT-1 in the TIMEOUT-th enable cycle;
  // if no data_ready arrives in that cycle the job times out and mmu_enable
  // has been high for exactly TIMEOUT cycles.
  //
  // A data_ready in the same cycle as the watchdog expiry still completes
  // the operation; abort wins over both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last_k  <= '0;
      k_q     <= '0;
      acc_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wd_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      done_q <= 1'b0;

      if (bus.abort && (state == ISSUE || state == GAP)) begin
        // Abort drops the job silently: no done, error left as it was.
        state  <= IDLE;
        en_q   <= 1'b0;
        busy_q <= 1'b0;
        k_q    <= '0;
        acc_q  <= 1'b0;
      end else begin
        case (state)
          IDLE, ERR: begin
            // ERR behaves exactly like IDLE except that error stays set
            // until the next accepted start.
            if (bus.start) begin
              err_q <= 1'b0;
              if (bus.num_k_tiles != '0) begin
                last_k <= bus.num_k_tiles - KT_W'(1);
                k_q    <= '0;
                acc_q  <= 1'b0;
                busy_q <= 1'b1;
                en_q   <= 1'b1;
                wd_cnt <= '0;
                state  <= ISSUE;
              end else begin
                // An empty job completes immediately without touching the MMU.
                done_q <= 1'b1;
                state  <= IDLE;
              end
            end
          end

          ISSUE: begin
            if (bus.mmu_data_ready) begin
              en_q <= 1'b0;
              if (k_q == last_k) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                state  <= IDLE;
              end else begin
                gap_cnt <= '0;
                state   <= GAP;
              end
            end else if (wd_cnt == WD_LAST) begin
              en_q   <= 1'b0;
              busy_q <= 1'b0;
              err_q  <= 1'b1;
              state  <= ERR;
            end else begin
              wd_cnt <= wd_cnt + TO_W'(1);
            end
          end

          GAP: begin
            // Operand selects move only here, while mmu_enable is low, so
            // the MMU sees stable operands for its whole enable window.
            if (gap_cnt == GAP_LAST) begin
              k_q    <= k_q + KT_W'(1);
              acc_q  <= 1'b1;
              en_q   <= 1'b1;
              wd_cnt <= '0;
              state  <= ISSUE;
            end else begin
              gap_cnt <= gap_cnt + GC_W'(1);
            end
          end

          default: begin
            state  <= IDLE;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = err_q;
  assign bus.mmu_enable = en_q;
  assign bus.k_idx      = k_q;
  assign bus.accum_sel  = acc_q;

endmodule

// File: tb/tb_mmu_tile_seq.sv
// tb_mmu_tile_seq
//   Self-checking bench for mmu_tile_seq. The whole run is planned up front as
//   a cycle timeline: for each job the bench picks MMU latencies, aborts and
//   timeouts, writes the input schedule, and derives from the job arithmetic
//   (window start + latency + gap) what every output must be in every cycle.
//   One loop then replays the inputs and compares the DUT cycle by cycle.
//   A few hand-computed literal expectations pin the directed scenarios, and
//   an asynchronous reset mid-job is exercised at the end.
module tb_mmu_tile_seq;

  localparam int KT_W       = 4;
  localparam int GAP_CYCLES = 1;
  localparam int TIMEOUT    = 15;
  localparam int TO_W       = 4;
  localparam int MAXC       = 8192;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mmu_tile_seq_if #(.KT_W(KT_W)) bus ();

  mmu_tile_seq #(
    .KT_W      (KT_W),
    .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT   (TIMEOUT),
    .TO_W      (TO_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Input schedule, indexed by cycle
  bit st_start [MAXC];
  int st_n     [MAXC];
  bit st_abort [MAXC];
  bit st_dr    [MAXC];

  // Expected outputs, indexed by cycle
  bit ex_busy [MAXC];
  bit ex_done [MAXC];
  bit ex_err  [MAXC];
  bit ex_en   [MAXC];
  bit ex_kv   [MAXC];
  int ex_k    [MAXC];
  bit ex_acc  [MAXC];

  int cur;
  int total;
  bit m_err;
  int n_checks;
  int n_errors;

  // Hand-computed literal expectations: cycle, signal id, value
  int pin_c[$];
  int pin_s[$];
  int pin_v[$];
  string sig_name[6] = '{"busy", "done", "error", "mmu_enable", "k_idx", "accum_sel"};

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, c, act, exp);
    end
  endtask

  function automatic logic [31:0] sig_val(input int id);
    case (id)
      0:       return 32'(bus.busy);
      1:       return 32'(bus.done);
      2:       return 32'(bus.error);
      3:       return 32'(bus.mmu_enable);
      4:       return 32'(bus.k_idx);
      default: return 32'(bus.accum_sel);
    endcase
  endfunction

  task automatic add_pin(input int c, input int id, input int v);
    pin_c.push_back(c);
    pin_s.push_back(id);
    pin_v.push_back(v);
  endtask

  // Idle cycles: nothing running, error carries over; stray abort and
  // data_ready are optionally sprinkled in and must have no effect.
  task automatic idle(input int cnt, input bit stray);
    for (int j = 0; j < cnt; j++) begin
      ex_err[cur] = m_err;
      if (stray) begin
        st_abort[cur] = ($urandom_range(0, 3) == 0);
        st_dr[cur]    = ($urandom_range(0, 3) == 0);
      end
      cur++;
    end
  endtask

  // One cycle of a running job on tile i.
  task automatic job_cycle(input int c, input int i, input bit en, input bit stray);
    ex_busy[c] = 1'b1;
    ex_en[c]   = en;
    ex_kv[c]   = 1'b1;
    ex_k[c]    = i;
    ex_acc[c]  = (i > 0);
    ex_err[c]  = 1'b0;
    if (stray) begin
      if ($urandom_range(0, 5) == 0) begin
        st_start[c] = 1'b1;
        st_n[c]     = $urandom_range(0, 15);
      end
      if (!en && $urandom_range(0, 2) == 0) st_dr[c] = 1'b1;
    end
  endtask

  // Plan a job starting at cycle cur. fix_lat=0 draws latencies at random
  // (data_ready in the lat-th enable cycle). to_tile: tile whose MMU never
  // answers. ab_tile/ab_off: abort placed ab_off cycles into that tile's
  // enable+gap span (no abort if the offset falls outside the span).
  task automatic plan_job(input int n, input int fix_lat, input int to_tile,
                          input int ab_tile, input int ab_off, input bit stray);
    int s;
    int t;
    int lat;
    int span;
    int a;
    bit fin;
    s = cur;
    st_start[s] = 1'b1;
    st_n[s]     = n;
    ex_err[s]   = m_err;
    m_err       = 1'b0;
    if (n == 0) begin
      ex_done[s+1] = 1'b1;
      ex_err[s+1]  = 1'b0;
      cur = s + 1;
      return;
    end
    t   = s + 1;
    fin = 1'b0;
    for (int i = 0; i < n && !fin; i++) begin
      lat = (fix_lat > 0) ? fix_lat : $urandom_range(1, 5);
      if (i == to_tile) begin
        for (int j = 0; j < TIMEOUT; j++) job_cycle(t + j, i, 1'b1, stray);
        ex_err[t+TIMEOUT] = 1'b1;
        m_err = 1'b1;
        cur   = t + TIMEOUT;
        fin   = 1'b1;
      end else begin
        span = lat + ((i == n - 1) ? 0 : GAP_CYCLES);
        a    = (i == ab_tile && ab_off < span) ? ab_off : span;
        for (int j = 0; j < span && j <= a; j++) job_cycle(t + j, i, (j < lat), stray && (j < a));
        if (a >= lat - 1) st_dr[t+lat-1] = 1'b1;
        if (a < span) begin
          st_abort[t+a] = 1'b1;
          ex_kv[t+a+1]  = 1'b1;
          ex_k[t+a+1]   = 0;
          ex_acc[t+a+1] = 1'b0;
          ex_err[t+a+1] = 1'b0;
          cur = t + a + 1;
          fin = 1'b1;
        end else if (i == n - 1) begin
          ex_done[t+lat] = 1'b1;
          ex_err[t+lat]  = 1'b0;
          cur = t + lat;
          fin = 1'b1;
        end else begin
          t = t + span;
        end
      end
    end
  endtask

  task automatic build_schedule();
    int s;
    int n;
    int to_t;
    int ab_t;
    int jobs;
    cur   = 0;
    m_err = 1'b0;
    idle(2, 1'b0);

    // Single tile, nominal latency
    s = cur;
    plan_job(1, 3, -1, -1, 0, 1'b0);
    add_pin(s + 1, 3, 1); add_pin(s + 3, 3, 1); add_pin(s + 4, 3, 0);
    add_pin(s + 3, 1, 0); add_pin(s + 4, 1, 1);
    add_pin(s + 3, 0, 1); add_pin(s + 4, 0, 0);
    add_pin(s + 2, 4, 0); add_pin(s + 2, 5, 0);
    idle(1, 1'b0);

    // Three tiles
    s = cur;
    plan_job(3, 3, -1, -1, 0, 1'b0);
    add_pin(s + 4, 3, 0); add_pin(s + 5, 3, 1); add_pin(s + 8, 3, 0);
    add_pin(s + 9, 3, 1); add_pin(s + 11, 3, 1);
    add_pin(s + 2, 5, 0); add_pin(s + 6, 5, 1); add_pin(s + 6, 4, 1); add_pin(s + 10, 4, 2);
    add_pin(s + 11, 1, 0); add_pin(s + 12, 1, 1); add_pin(s + 12, 0, 0);
    idle(1, 1'b0);

    // Zero tiles
    s = cur;
    plan_job(0, 3, -1, -1, 0, 1'b0);
    add_pin(s + 1, 1, 1); add_pin(s + 1, 0, 0); add_pin(s + 1, 3, 0);
    idle(1, 1'b0);

    // Timeout on the first tile, then a normal job clears error
    s = cur;
    plan_job(2, 3, 0, -1, 0, 1'b0);
    add_pin(s + 15, 3, 1); add_pin(s + 16, 3, 0);
    add_pin(s + 15, 2, 0); add_pin(s + 16, 2, 1); add_pin(s + 16, 0, 0);
    idle(2, 1'b0);
    s = cur;
    plan_job(1, 3, -1, -1, 0, 1'b0);
    add_pin(s, 2, 1); add_pin(s + 1, 2, 0); add_pin(s + 4, 1, 1);
    idle(1, 1'b0);

    // Abort in the 3rd enable cycle of tile 1, coinciding with data_ready
    s = cur;
    plan_job(4, 3, -1, 1, 2, 1'b0);
    add_pin(s + 7, 3, 1); add_pin(s + 8, 3, 0); add_pin(s + 8, 0, 0);
    add_pin(s + 8, 1, 0); add_pin(s + 8, 4, 0);
    idle(1, 1'b0);

    // Start with N=7 while an N=2 job runs
    s = cur;
    plan_job(2, 3, -1, -1, 0, 1'b0);
    st_start[s+2] = 1'b1;
    st_n[s+2]     = 7;
    add_pin(s + 8, 1, 1); add_pin(s + 8, 0, 0); add_pin(s + 9, 3, 0);
    idle(2, 1'b0);

    // Randomised jobs
    jobs = 0;
    while (cur < MAXC - 300 && jobs < 80) begin
      idle($urandom_range(0, 3), 1'b1);
      n    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 5);
      to_t = (n > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
      ab_t = (n > 0 && to_t < 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      plan_job(n, 0, to_t, ab_t, $urandom_range(0, 6), 1'b1);
      jobs++;
    end
    idle(3, 1'b0);
    total = cur;
  endtask

  task automatic applyStimulus(input int c);
    bus.start          = st_start[c];
    bus.num_k_tiles    = KT_W'(st_n[c]);
    bus.abort          = st_abort[c];
    bus.mmu_data_ready = st_dr[c];
  endtask

  task automatic checkOutput(input int c);
    check("busy", c, 32'(bus.busy), 32'(ex_busy[c]));
    check("done", c, 32'(bus.done), 32'(ex_done[c]));
    check("error", c, 32'(bus.error), 32'(ex_err[c]));
    check("mmu_enable", c, 32'(bus.mmu_enable), 32'(ex_en[c]));
    if (ex_kv[c]) begin
      check("k_idx", c, 32'(bus.k_idx), 32'(ex_k[c]));
      check("accum_sel", c, 32'(bus.accum_sel), 32'(ex_acc[c]));
    end
    for (int p = 0; p < pin_c.size(); p++) begin
      if (pin_c[p] == c) check({"pin_", sig_name[pin_s[p]]}, c, sig_val(pin_s[p]), 32'(pin_v[p]));
    end
  endtask

  initial begin
    bus.start          = 1'b0;
    bus.num_k_tiles    = '0;
    bus.abort          = 1'b0;
    bus.mmu_data_ready = 1'b0;
    build_schedule();
    $display("[TB] planned %0d cycles", total);

    repeat (2) @(negedge clk);
    for (int id = 0; id < 6; id++) check({"reset_", sig_name[id]}, -1, sig_val(id), 32'd0);
    rst_n = 1'b1;

    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      checkOutput(c);
      applyStimulus(c);
    end

    // Asynchronous reset in the middle of the second tile of an N=2 job
    @(negedge clk);
    bus.start       = 1'b1;
    bus.num_k_tiles = KT_W'(2);
    @(negedge clk);
    bus.start = 1'b0;
    check("rst_job_en_c1", 1, 32'(bus.mmu_enable), 32'd1);
    @(negedge clk);
    @(negedge clk);
    bus.mmu_data_ready = 1'b1;
    @(negedge clk);
    bus.mmu_data_ready = 1'b0;
    check("rst_job_gap_en", 4, 32'(bus.mmu_enable), 32'd0);
    @(negedge clk);
    check("rst_job_en_c5", 5, 32'(bus.mmu_enable), 32'd1);
    check("rst_job_k_c5", 5, 32'(bus.k_idx), 32'd1);
    check("rst_job_acc_c5", 5, 32'(bus.accum_sel), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int id = 0; id < 6; id++) check({"async_reset_", sig_name[id]}, 5, sig_val(id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mmu_data_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      bus.mmu_data_ready = 1'b0;
      check("post_reset_done", 6 + j, 32'(bus.done), 32'd0);
      check("post_reset_busy", 6 + j, 32'(bus.busy), 32'd0);
      check("post_reset_en", 6 + j, 32'(bus.mmu_enable), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
